// File: rtl/mem_access_unit.sv
// mem_access_unit
// Requester-side load/store engine for the MEM stage. It accepts one
// load/store at a time and drives a word-wide data port. Sub-word loads are
// aligned and extended. Sub-word stores are done as read-modify-write,
// because the memory only takes whole-word writes. Misaligned accesses and
// unknown opcodes are reported as errors and never reach memory.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake; accepted when both are high at an edge
//   req_op            MIPS opcode (lb lh lw lbu lhu sb sh sw)
//   req_addr          byte address
//   req_wdata         store data (low bits for sb/sh)
//   rsp_valid         one-cycle response strobe
//   rsp_rdata         extended load result; 0 for stores and errors
//   rsp_err           misaligned or unsupported op (qualified by rsp_valid)
//   mem_addr          word-aligned memory address
//   mem_wr_en         one-cycle memory write enable
//   mem_din           write word to memory
//   mem_dout          combinational read word at mem_addr
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [1:0]  state_reg;
  logic [5:0]  op_reg;
  logic [1:0]  off_reg;
  // Only the low halfword is ever merged; sw writes req_wdata directly.
  logic [15:0] wdata_reg;

  // Request decode (combinational, used only on the accept edge)
  logic accept;
  logic req_bad_op;
  logic req_misaligned;
  logic req_err;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_bad_op     = 1'b0;
    req_misaligned = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: req_misaligned = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
      OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
      default:              req_bad_op     = 1'b1;
    endcase
  end

  // Opcode is checked first; an unknown op is an error regardless of address.
  assign req_err = req_bad_op || req_misaligned;

  // Lane positions of the latched access within the word.
  // Big-endian: offset 0 is the most significant byte.
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh = BIG_ENDIAN ? {~off_reg, 3'b000} : {off_reg, 3'b000};
  assign half_sh = BIG_ENDIAN ? {~off_reg[1], 4'b0000} : {off_reg[1], 4'b0000};

  assign load_byte = 8'(mem_dout >> byte_sh);
  assign load_half = 16'(mem_dout >> half_sh);
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  always_comb begin
    load_data = mem_dout;
    case (op_reg)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'h0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'h0, load_half};
      default: load_data = mem_dout;
    endcase
  end

  always_comb begin
    merge_data = mem_dout;
    case (op_reg)
      OP_SB:   merge_data = (mem_dout & ~byte_mask) | (32'(wdata_reg[7:0]) << byte_sh);
      OP_SH:   merge_data = (mem_dout & ~half_mask) | (32'(wdata_reg) << half_sh);
      default: merge_data = mem_dout;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_reg    <= 6'h0;
      off_reg   <= 2'b00;
      wdata_reg <= 16'h0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_din   <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= req_op;
            off_reg   <= req_addr[1:0];
            wdata_reg <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (req_err) begin
              state_reg <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_op == OP_SW) begin
                state_reg <= S_WR;
                mem_wr_en <= 1'b1;
                mem_din   <= req_wdata;
              end else begin
                state_reg <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          // Opcode bit 3 separates stores (sb/sh here) from loads.
          if (!op_reg[3]) begin
            state_reg <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end else begin
            state_reg <= S_WR;
            mem_wr_en <= 1'b1;
            mem_din   <= merge_data;
          end
        end
        S_WR: begin
          state_reg <= S_DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: begin
          state_reg <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Memory attached to the DUT: 64 words, combinational read.
  logic [31:0] dmem [64];
  assign mem_dout = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr_en) dmem[mem_addr[7:2]] <= mem_din;

  // Reference model: a plain big-endian byte array (lowest address = MSB).
  logic [7:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    dmem[a >> 2] = v;
    for (int i = 0; i < 4; i++) ref_mem[(a & ~3) + i] = v[31 - 8*i -: 8];
  endtask

  function automatic logic [31:0] ref_word(input int a);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w = (w << 8) | 32'(ref_mem[(a & ~3) + i]);
    return w;
  endfunction

  task automatic do_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic        is_ld, is_st, sgn, err, got;
    int          sz, exp_lat, lat, wr_cnt, wr_n, a;
    logic [31:0] exp_rd, exp_din;
    is_ld = 1'b0; is_st = 1'b0; sgn = 1'b0; sz = 4; err = 1'b0;
    case (op)
      6'b100000: begin is_ld = 1; sz = 1; sgn = 1; end
      6'b100001: begin is_ld = 1; sz = 2; sgn = 1; end
      6'b100011: begin is_ld = 1; sz = 4; end
      6'b100100: begin is_ld = 1; sz = 1; end
      6'b100101: begin is_ld = 1; sz = 2; end
      6'b101000: begin is_st = 1; sz = 1; end
      6'b101001: begin is_st = 1; sz = 2; end
      6'b101011: begin is_st = 1; sz = 4; end
      default:   err = 1;
    endcase
    a = int'(addr[7:0]);
    if (!err && (a % sz) != 0) err = 1;
    exp_rd = 32'h0; exp_din = 32'h0;
    if (err) exp_lat = 1;
    else if (is_st && sz < 4) exp_lat = 3;
    else exp_lat = 2;
    if (!err && is_ld) begin
      for (int i = 0; i < sz; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[a + i]);
      if (sgn && exp_rd[8*sz-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*sz));
    end
    if (!err && is_st) begin
      for (int i = 0; i < sz; i++) ref_mem[a + i] = 8'(wdata >> (8*(sz-1-i)));
      exp_din = ref_word(a);
    end

    @(negedge clk);
    check("ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
    check("ready_busy", {31'h0, req_ready}, 32'h0);
    got = 1'b0; lat = 99; wr_cnt = 0; wr_n = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        wr_cnt++; wr_n = n;
        check("wr_din", mem_din, exp_din);
        check("wr_addr", mem_addr, addr & ~32'h3);
      end
      if (rsp_valid) begin got = 1'b1; lat = n; break; end
    end
    check("rsp_latency", lat, exp_lat);
    if (got) begin
      check("rsp_err", {31'h0, rsp_err}, {31'h0, err});
      check("rsp_rdata", rsp_rdata, exp_rd);
      if (!err) check("mem_addr", mem_addr, addr & ~32'h3);
    end
    check("wr_count", wr_cnt, (is_st && !err) ? 1 : 0);
    if (is_st && !err) check("wr_cycle", wr_n, exp_lat - 1);
    $display("txn op=%b addr=%h wdata=%h rdata=%h err=%b lat=%0d wr=%0d",
             op, addr, wdata, rsp_rdata, rsp_err, lat, wr_cnt);
  endtask

  logic [5:0] good_ops [8] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                               6'b100101, 6'b101000, 6'b101001, 6'b101011};
  logic [5:0] bad_ops  [5] = '{6'b000000, 6'b100010, 6'b101010, 6'b111111, 6'b100110};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 6'h0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) set_word(i * 4, $urandom);
    set_word(32'h08, 32'h24230004);
    set_word(32'h04, 32'h2023F004);
    set_word(32'h10, 32'h11223344);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    rst = 1'b0;

    // Directed cases
    do_req(6'b100011, 32'h08, 32'h0);          // lw
    do_req(6'b100000, 32'h06, 32'h0);          // lb
    do_req(6'b100100, 32'h06, 32'h0);          // lbu
    do_req(6'b100001, 32'h06, 32'h0);          // lh
    do_req(6'b100101, 32'h04, 32'h0);          // lhu
    do_req(6'b101000, 32'h11, 32'hABCDEFAA);   // sb
    do_req(6'b101001, 32'h12, 32'h0000BEEF);   // sh
    check("sh_word", dmem[4], 32'h11AABEEF);
    do_req(6'b101011, 32'h14, 32'hDEADBEEF);   // sw
    do_req(6'b100011, 32'h14, 32'h0);          // lw readback
    do_req(6'b100011, 32'h02, 32'h0);          // misaligned lw
    do_req(6'b101001, 32'h03, 32'h1234);       // misaligned sh
    check("sh_err_word", dmem[0], ref_word(0));
    do_req(6'b000000, 32'h00, 32'h0);          // unsupported

    // Reset while sb is in RD: nothing may complete.
    @(negedge clk);
    req_valid = 1'b1; req_op = 6'b101000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    check("mid_rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_mem_din", mem_din, 32'h0);
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_rsp_valid2", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    check("mid_rst_word", dmem[4], 32'h11AABEEF);
    do_req(6'b100011, 32'h10, 32'h0);

    // Randomized traffic against the byte-array model
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
      else op = good_ops[$urandom_range(0, 7)];
      do_req(op, 32'($urandom_range(0, 255)), $urandom);
    end
    for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_word(i * 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Requester-side load/store engine for the MEM stage; drives the byte-addressed, big-endian, 32-bit-word data port of the shared instruction/data memory.
- Accepts one pipeline load/store request at a time.
- Aligns sub-word loads and sign- or zero-extends them.
- Implements sb/sh as read-modify-write, because the memory only supports whole-word writes.
- Flags misaligned or unsupported accesses instead of touching memory.

Parameters:
- ADDR_W, 32, byte address width.
- BIG_ENDIAN, 1, 1: byte offset o maps to word bits [31-8o:24-8o]; 0: offset o maps to bits [8o+7:8o].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted on a clk edge where req_valid && req_ready.
- req_op  in  6  MIPS opcode: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the value is in the low bits for sb/sh.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; high for misaligned or unsupported op.
- mem_addr  out  ADDR_W  word-aligned data address to memory (low 2 bits always 0).
- mem_wr_en  out  1  memory write enable.
- mem_din  out  32  write word to memory.
- mem_dout  in  32  combinational read word from memory at mem_addr.

Behaviour:
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_wr_en=0, mem_addr=0, mem_din=0.
  - Any in-flight access is abandoned; no partial write may complete after reset asserts.
- All outputs are registered. mem_addr and mem_din change only on the edge entering RD or WR. While mem_wr_en=1 they are stable. mem_wr_en is high for exactly one cycle per store.
- On acceptance, the unit latches op, addr, and wdata. Requests arriving while req_ready=0 are ignored.
- Check order on acceptance: unsupported opcode, then alignment.
  - Unsupported opcode -> error.
  - Alignment errors: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0 -> error.
- States:
  - IDLE: req_ready=1. On accept:
    - Error -> DONE.
    - sw -> WR, with mem_din=wdata.
    - All other ops -> RD.
    - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - RD: req_ready=0. Sample mem_dout at the cycle end.
    - Loads -> DONE, with rsp_rdata formed from the sampled word.
    - sb/sh -> WR, with mem_din = sampled word with the target lane(s) replaced.
  - WR: mem_wr_en=1 for this cycle -> DONE.
  - DONE: rsp_valid=1 for one cycle. rsp_err is set per the checks above. Next state is IDLE; req_ready returns to 1 on the following cycle. There is no back-to-back acceptance in DONE.
- Latency from the accept edge to the rsp_valid cycle:
  - Error: 1 cycle.
  - Load or sw: 2 cycles.
  - sb or sh: 3 cycles.
- Lane selection with BIG_ENDIAN=1:
  - Byte at offset o is bits [31-8o -: 8].
  - Halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Extension and merge rules:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - sb writes wdata[7:0] into its lane; sh writes wdata[15:0] into its lane. Other lanes are preserved bit-exact.
- Errors never assert mem_wr_en.
- If rst asserts during WR, mem_wr_en drops asynchronously. The memory word may already be written; the response is lost.

Test Plan:
- Reset, then lw addr 0x8 with memory word 0x24230004 -> rsp_valid at accept+2, rsp_rdata=0x24230004, rsp_err=0, mem_addr=0x8, mem_wr_en never high.
- Memory word at 0x4 = 0x2023F004:
  - lb addr 0x6 -> rsp_rdata=0xFFFFFFF0.
  - lbu addr 0x6 -> rsp_rdata=0x000000F0.
  - lh addr 0x6 -> rsp_rdata=0xFFFFF004.
  - lhu addr 0x4 -> rsp_rdata=0x00002023.
- Memory word at 0x10 = 0x11223344:
  - sb addr 0x11, wdata 0xABCDEFAA -> one-cycle mem_wr_en at accept+2 with mem_din=0x11AA3344; rsp at accept+3.
  - Then sh addr 0x12, wdata 0x0000BEEF -> word becomes 0x11AABEEF.
- sw addr 0x14, wdata 0xDEADBEEF -> mem_wr_en at accept+1, mem_din=0xDEADBEEF, mem_addr=0x14; rsp at accept+2; readback by lw returns 0xDEADBEEF.
- Error cases:
  - lw addr 0x2 -> rsp at accept+1, rsp_err=1, rsp_rdata=0.
  - sh addr 0x3 -> rsp_err=1 and the word is unchanged.
  - req_op=000000 -> rsp_err=1.
  - mem_wr_en stays 0 throughout.
- Assert rst mid-sb while in RD -> outputs return to reset values immediately, memory is unchanged, no rsp_valid. A new lw after release completes normally.
